sobel_window_gen: RTL and testbench



---
 rtl/sobel_pkg.sv | 23 ++
 rtl/sobel_line_ram.sv | 24 ++
 rtl/sobel_window_gen.sv | 117 +++++++++++
 tb/tb_sobel_window_gen.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel window generator: default geometry,
// counter widths and 3x3 window element indices (index = 3*row + col).
package sobel_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int IMG_W_DEF  = 640;
   localparam int IMG_H_DEF  = 480;

   localparam int X_W_DEF = $clog2(IMG_W_DEF);
   localparam int Y_W_DEF = $clog2(IMG_H_DEF);

   // row 0 is line y-2, col 0 is column x-2
   localparam int W00 = 0;
   localparam int W01 = 1;
   localparam int W02 = 2;
   localparam int W10 = 3;
   localparam int W11 = 4;
   localparam int W12 = 5;
   localparam int W20 = 6;
   localparam int W21 = 7;
   localparam int W22 = 8;

endpackage

// File: rtl/sobel_line_ram.sv
// Single-port line memory: combinational read, registered write.
// Contents are deliberately not reset.
module sobel_line_ram #(
   parameter int DEPTH  = 640,
   parameter int DATA_W = 8,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   assign rdata = mem[addr];

   // write the addressed entry on an accepted pixel
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

endmodule

// File: rtl/sobel_window_gen.sv
// Sobel 3x3 window generator: buffers two lines of a raster pixel stream and
// emits a registered window for every interior pixel position.
// Optional build macro SOBEL_WIN_EOF_EN adds win_eof, flagging the last
// window of each frame.
module sobel_window_gen
   import sobel_pkg::*;
#(
   parameter int IMG_W  = IMG_W_DEF,
   parameter int IMG_H  = IMG_H_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [DATA_W-1:0]         pix_data,
   input  logic                      pix_valid,
   input  logic                      pix_sof,
   output logic [9*DATA_W-1:0]       win_data,
   output logic                      win_valid,
   output logic [$clog2(IMG_W)-1:0]  win_x,
   output logic [$clog2(IMG_H)-1:0]  win_y
`ifdef SOBEL_WIN_EOF_EN
   ,
   output logic                      win_eof
`endif
);

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

   logic [XW-1:0]     x_cnt, cur_x, nxt_x;
   logic [YW-1:0]     y_cnt, cur_y, nxt_y;
   logic              in_win;
   logic              ram_we;
   logic [DATA_W-1:0] lb0_rd, lb1_rd;

   // a pixel that arrives with reset is dropped, so memories must not see it
   assign ram_we = pix_valid & ~reset;

   // sof forces the current pixel to (0,0); compute the position after it
   always_comb begin
      cur_x = pix_sof ? '0 : x_cnt;
      cur_y = pix_sof ? '0 : y_cnt;
      nxt_x = cur_x + XW'(1);
      nxt_y = cur_y;
      if (cur_x == X_LAST) begin
         nxt_x = '0;
         nxt_y = (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
      end
      in_win = (cur_x >= XW'(2)) && (cur_y >= YW'(2));
   end

   // lb0 holds line y-2, lb1 holds line y-1; lb1's old entry ages into lb0
   sobel_line_ram #(.DEPTH(IMG_W), .DATA_W(DATA_W), .AW(XW)) u_lb0 (
      .clk   (clk),
      .we    (ram_we),
      .addr  (cur_x),
      .wdata (lb1_rd),
      .rdata (lb0_rd)
   );

   sobel_line_ram #(.DEPTH(IMG_W), .DATA_W(DATA_W), .AW(XW)) u_lb1 (
      .clk   (clk),
      .we    (ram_we),
      .addr  (cur_x),
      .wdata (pix_data),
      .rdata (lb1_rd)
   );

   // raster position counters, advancing only on accepted pixels
   always_ff @(posedge clk) begin
      if (reset) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else if (pix_valid) begin
         x_cnt <= nxt_x;
         y_cnt <= nxt_y;
      end
   end

   // window shift register and registered valid/centre outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         win_data  <= '0;
         win_valid <= 1'b0;
         win_x     <= '0;
         win_y     <= '0;
      end else begin
         win_valid <= pix_valid & in_win;
         if (pix_valid) begin
            win_data[DATA_W*W00 +: DATA_W] <= win_data[DATA_W*W01 +: DATA_W];
            win_data[DATA_W*W01 +: DATA_W] <= win_data[DATA_W*W02 +: DATA_W];
            win_data[DATA_W*W02 +: DATA_W] <= lb0_rd;
            win_data[DATA_W*W10 +: DATA_W] <= win_data[DATA_W*W11 +: DATA_W];
            win_data[DATA_W*W11 +: DATA_W] <= win_data[DATA_W*W12 +: DATA_W];
            win_data[DATA_W*W12 +: DATA_W] <= lb1_rd;
            win_data[DATA_W*W20 +: DATA_W] <= win_data[DATA_W*W21 +: DATA_W];
            win_data[DATA_W*W21 +: DATA_W] <= win_data[DATA_W*W22 +: DATA_W];
            win_data[DATA_W*W22 +: DATA_W] <= pix_data;
            if (in_win) begin
               win_x <= cur_x - XW'(1);
               win_y <= cur_y - YW'(1);
            end
         end
      end
   end

`ifdef SOBEL_WIN_EOF_EN
   // flag the window whose newest pixel is the last pixel of the frame
   always_ff @(posedge clk) begin
      if (reset) win_eof <= 1'b0;
      else       win_eof <= pix_valid & (cur_x == X_LAST) & (cur_y == Y_LAST);
   end
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// Randomized bench for sobel_window_gen on an 8x6 image, pixel = 16*y + x.
module tb_sobel_window_gen;

   localparam int IMG_W = 8;
   localparam int IMG_H = 6;
   localparam int NPIX  = IMG_W * IMG_H;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  pix_data;
   logic        pix_valid;
   logic        pix_sof;
   logic [71:0] win_data;
   logic        win_valid;
   logic [2:0]  win_x;
   logic [2:0]  win_y;
   logic        win_eof;

   always #5 clk = ~clk;

   sobel_window_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .pix_data  (pix_data),
      .pix_valid (pix_valid),
      .pix_sof   (pix_sof),
      .win_data  (win_data),
      .win_valid (win_valid),
      .win_x     (win_x),
      .win_y     (win_y)
`ifdef SOBEL_WIN_EOF_EN
      ,
      .win_eof   (win_eof)
`endif
   );

`ifndef SOBEL_WIN_EOF_EN
   assign win_eof = 1'b0;
`endif

   typedef struct {
      logic [71:0] d;
      int          x;
      int          y;
      bit          eof;
   } win_t;

   int   errors = 0;
   int   checks = 0;
   win_t exp_q[$];
   win_t obs_q[$];
   logic [7:0] frm [IMG_H][IMG_W];
   int   mx = 0;
   int   my = 0;
   bit   exp_v_drv = 1'b0;
   bit   exp_v = 1'b0;
   bit   mon_en = 1'b0;

   task automatic chk(input string tag, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] el(input logic [71:0] d, input int i);
      return d[8*i +: 8];
   endfunction

   // reference: image held as a 2D array; a window is the 3x3 block ending at
   // the current pixel whenever that pixel lies at x>=2, y>=2
   task automatic model_pix(input logic [7:0] d, input bit sof);
      win_t w;
      int   pos;
      if (sof) begin
         mx = 0;
         my = 0;
      end
      frm[my][mx] = d;
      exp_v_drv = (mx >= 2) && (my >= 2);
      if (exp_v_drv) begin
         w.d = '0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               w.d[8*(3*r+c) +: 8] = frm[my-2+r][mx-2+c];
         w.x   = mx - 1;
         w.y   = my - 1;
         w.eof = (mx == IMG_W-1) && (my == IMG_H-1);
         exp_q.push_back(w);
      end
      pos = (my*IMG_W + mx + 1) % NPIX;
      mx  = pos % IMG_W;
      my  = pos / IMG_W;
   endtask

   task automatic cyc(input bit v, input bit sof, input logic [7:0] d);
      @(posedge clk);
      #1;
      reset     = 1'b0;
      pix_valid = v;
      pix_sof   = sof;
      pix_data  = d;
      if (v) model_pix(d, sof);
      else   exp_v_drv = 1'b0;
   endtask

   // one-cycle reset with a pixel presented at the same time (must be dropped)
   task automatic do_reset();
      @(posedge clk);
      #1;
      reset     = 1'b1;
      pix_valid = 1'b1;
      pix_sof   = 1'b0;
      pix_data  = 8'hAA;
      exp_v_drv = 1'b0;
      mx = 0;
      my = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
   endtask

   task automatic send_frame(input int gap_pct, input bit sof, input int first, input int last);
      for (int idx = first; idx <= last; idx++) begin
         for (int g = 0; g < 8 && $urandom_range(99) < gap_pct; g++) cyc(1'b0, 1'b0, 8'h00);
         cyc(1'b1, sof && (idx == first), 8'((idx / IMG_W) * 16 + (idx % IMG_W)));
      end
   endtask

   task automatic chk_win(input string tag, input int idx, input logic [7:0] w00,
                          input logic [7:0] w11, input logic [7:0] w22, input int x, input int y);
      if (obs_q.size() > idx) begin
         chk({tag, "_w00"}, el(obs_q[idx].d, 0), w00);
         chk({tag, "_w11"}, el(obs_q[idx].d, 4), w11);
         chk({tag, "_w22"}, el(obs_q[idx].d, 8), w22);
         chk({tag, "_x"}, obs_q[idx].x, x);
         chk({tag, "_y"}, obs_q[idx].y, y);
      end else begin
         chk({tag, "_present"}, obs_q.size(), idx + 1);
      end
   endtask

   always @(posedge clk) exp_v <= exp_v_drv;

   // compare every DUT window against the reference queue
   always @(negedge clk) begin
      if (mon_en) begin
         chk("win_valid", win_valid, exp_v);
         if (win_valid) begin
            win_t o;
            win_t e;
            o.d = win_data;
            o.x = int'(win_x);
            o.y = int'(win_y);
            o.eof = win_eof;
            obs_q.push_back(o);
            if (exp_q.size() == 0) begin
               chk("spurious_win", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("win_data", o.d, e.d);
               chk("win_x", o.x, e.x);
               chk("win_y", o.y, e.y);
`ifdef SOBEL_WIN_EOF_EN
               chk("win_eof", o.eof, e.eof);
`endif
            end
         end
`ifdef SOBEL_WIN_EOF_EN
         else begin
            chk("win_eof_idle", win_eof, 1'b0);
         end
`endif
      end
   end

   initial begin
      reset     = 1'b1;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      pix_data  = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", win_valid, 1'b0);
      chk("rst_data", win_data, 72'h0);
      chk("rst_x", win_x, 3'd0);
      chk("rst_y", win_y, 3'd0);
      mon_en = 1'b1;

      // continuous frame with sof
      obs_q.delete();
      send_frame(0, 1'b1, 0, NPIX-1);
      idle(3);
      chk("s1_count", obs_q.size(), 24);
      chk_win("s1_first", 0, 8'h00, 8'h11, 8'h22, 1, 1);
      chk_win("s2_last", 23, 8'h35, 8'h46, 8'h57, 6, 4);
`ifdef SOBEL_WIN_EOF_EN
      begin
         int n_eof = 0;
         foreach (obs_q[i]) if (obs_q[i].eof) n_eof++;
         chk("s2_eof_count", n_eof, 1);
         if (obs_q.size() > 0) chk("s2_eof_last", obs_q[obs_q.size()-1].eof, 1'b1);
      end
`endif

      // random gaps
      obs_q.delete();
      send_frame(50, 1'b1, 0, NPIX-1);
      idle(3);
      chk("s3_count", obs_q.size(), 24);
      chk_win("s3_first", 0, 8'h00, 8'h11, 8'h22, 1, 1);
      chk_win("s3_last", 23, 8'h35, 8'h46, 8'h57, 6, 4);

      // reset after pixel (3,3), then restart without sof
      send_frame(0, 1'b1, 0, 3*IMG_W + 3);
      idle(2);
      do_reset();
      obs_q.delete();
      send_frame(0, 1'b0, 0, NPIX-1);
      idle(3);
      chk("s4_count", obs_q.size(), 24);
      chk_win("s4_first", 0, 8'h00, 8'h11, 8'h22, 1, 1);

      // sof arriving at pixel (5,2) resynchronises the counters
      send_frame(0, 1'b1, 0, 2*IMG_W + 4);
      idle(2);
      obs_q.delete();
      cyc(1'b1, 1'b1, 8'h00);
      send_frame(0, 1'b0, 1, NPIX-1);
      idle(3);
      chk("s5_count", obs_q.size(), 24);
      chk_win("s5_first", 0, 8'h00, 8'h11, 8'h22, 1, 1);
      chk_win("s5_last", 23, 8'h35, 8'h46, 8'h57, 6, 4);

      // two back-to-back frames, second relies on counter wrap
      obs_q.delete();
      send_frame(0, 1'b1, 0, NPIX-1);
      send_frame(0, 1'b0, 0, NPIX-1);
      idle(3);
      chk("s6_count", obs_q.size(), 48);
      chk_win("s6_f2_first", 24, 8'h00, 8'h11, 8'h22, 1, 1);
      chk_win("s6_f2_last", 47, 8'h35, 8'h46, 8'h57, 6, 4);

      chk("exp_q_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
